rom_bus_arbiter: RTL and testbench
==================================

ROM_BUS_ARBITER -- requirements
Module: rom_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning: maximum cycles a grant is held waiting for slave ack (legal range 2..255).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset. Clock and reset ports are named as the codebase does.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 m0_addr_i / m1_addr_i  input  32  master address.
REQ-006 m0_data_i / m1_data_i  input  32  master write data.
REQ-007 m0_we_i / m1_we_i  input  1  master write enable.
REQ-008 m0_sel_i / m1_sel_i  input  4  master byte select.
REQ-009 m0_stb_i / m1_stb_i  input  1  master strobe.
REQ-010 m0_cyc_i / m1_cyc_i  input  1  master bus cycle.
REQ-011 m0_data_o / m1_data_o  output  32  read data, equal to s_data_i at all times; valid only with ack.
REQ-012 m0_ack_o / m1_ack_o  output  1  transfer acknowledge to the granted master.
REQ-013 m0_err_o / m1_err_o  output  1  one-cycle timeout error to the granted master.
REQ-014 s_addr_o, s_data_o (32), s_we_o (1), s_sel_o (4), s_stb_o (1), s_cyc_o (1)  output  slave-side Wishbone request.
REQ-015 s_data_i  input  32  slave read data.
REQ-016 s_ack_i  input  1  slave acknowledge.
REQ-017 grant_o  output  2  one-hot current grant: bit0 for m0, bit1 for m1, 00 when idle.

Function
REQ-018 Request definitions: req0 = m0_cyc_i & m0_stb_i; req1 = m1_cyc_i & m1_stb_i.
REQ-019 FSM states SHALL be IDLE, GRANT0 and GRANT1, with a 1-bit last-served pointer.
REQ-020 IDLE transitions:
- req0 only -> GRANT0.
- req1 only -> GRANT1.
- both -> grant the master not last served; pointer updates on each grant.
- none -> stay in IDLE.
REQ-021 In IDLE, s_cyc_o, s_stb_o and all ack/err outputs SHALL be 0. s_addr_o, s_data_o, s_we_o and s_sel_o SHALL be 0.
REQ-022 In GRANTn:
- slave request outputs SHALL combinationally mirror master n inputs.
- s_cyc_o/s_stb_o = master n cyc/stb.
REQ-023 mn_ack_o SHALL equal s_ack_i & grant_o[n] & reqn, combinationally. The non-granted master's ack and err SHALL be 0.
REQ-024 Latency: a request sampled in IDLE at edge t SHALL appear on the slave from cycle t+1.
REQ-025 When s_ack_i=1 in GRANTn, the FSM SHALL return to IDLE on the next edge. This gives at least one idle cycle (s_cyc_o=0) between consecutive transfers, so the slave's request edge detection re-arms.
REQ-026 If master n drops cyc while in GRANTn, the FSM SHALL go to IDLE on the next edge with no ack or err.
REQ-027 Wait counter:
- 8-bit, cleared on entry to GRANTn.
- Increments each GRANTn cycle without ack.
- When count == TIMEOUT-1 with no ack: mn_err_o=1 for that cycle, then IDLE next edge.
REQ-028 Ack and timeout in the same cycle: ack wins and err stays 0.
REQ-029 A master whose request is not granted SHALL see ack=0 and err=0 until granted. There is no starvation: with both requesting continuously, grants alternate.

Reset
REQ-030 With rst=1 at an edge, the block SHALL take the following values at that edge, regardless of the current state or any in-flight transfer:
- state = IDLE.
- pointer = 1, so m0 wins the first tie.
- counter = 0.
- grant_o = 00.
- All ack/err = 0.
- s_cyc_o = s_stb_o = 0.
REQ-031 An in-flight transfer interrupted by reset SHALL NOT be acknowledged afterwards.

Verification
REQ-032 Single m0 read, slave ack 2 cycles after stb: s_stb_o high from cycle t+1; m0_ack_o=1 for one cycle with m0_data_o=s_data_i; grant_o returns to 00 the cycle after.
REQ-033 m0 and m1 request simultaneously after reset: m0 is served first, one idle cycle follows, then m1; repeated requests alternate m0, m1, m0.
REQ-034 Slave never acks, TIMEOUT=16: m0_err_o=1 exactly in the 16th GRANT0 cycle, then IDLE, with m0_ack_o=0 throughout.
REQ-035 Ack arrives in the same cycle count hits TIMEOUT-1: ack=1, err=0.
REQ-036 m1 drops cyc during GRANT1: IDLE next cycle, no ack/err; a pending m0 is granted after that.
REQ-037 rst=1 asserted during GRANT1 one cycle before slave ack: all outputs 0 next cycle; no ack is forwarded to m1.

Source files
------------

// File: rtl/rom_bus_arbiter.sv
// Two-master Wishbone arbiter in front of a single ROM/bus slave.
// Round-robin on ties, one idle cycle between transfers, per-grant ack timeout.
module rom_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_t;

  state_t     r_state, w_next_state;
  logic       r_last, w_next_last;   // 0: m0 served last, 1: m1 served last
  logic [7:0] r_cnt, w_next_cnt;
  logic       w_req0, w_req1, w_timeout;

  assign w_req0    = m0_cyc_i & m0_stb_i;
  assign w_req1    = m1_cyc_i & m1_stb_i;
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

  assign m0_data_o   = s_data_i;
  assign m1_data_o   = s_data_i;
  assign dbg_state_o = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next_state;
      r_last  <= w_next_last;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_last  = r_last;
    w_next_cnt   = r_cnt;
    grant_o      = 2'b00;
    s_addr_o     = 32'd0;
    s_data_o     = 32'd0;
    s_we_o       = 1'b0;
    s_sel_o      = 4'd0;
    s_stb_o      = 1'b0;
    s_cyc_o      = 1'b0;
    m0_ack_o     = 1'b0;
    m0_err_o     = 1'b0;
    m1_ack_o     = 1'b0;
    m1_err_o     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_cnt = 8'd0;
        if (w_req0 && (!w_req1 || r_last)) begin
          w_next_state = ST_GRANT0;
          w_next_last  = 1'b0;
        end else if (w_req1) begin
          w_next_state = ST_GRANT1;
          w_next_last  = 1'b1;
        end
      end
      ST_GRANT0: begin
        grant_o  = 2'b01;
        s_addr_o = m0_addr_i;
        s_data_o = m0_data_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_stb_o  = m0_stb_i;
        s_cyc_o  = m0_cyc_i;
        m0_ack_o = s_ack_i & w_req0;
        // Ack in the timeout cycle takes priority over the error.
        m0_err_o = m0_cyc_i & ~s_ack_i & w_timeout;
        if (!m0_cyc_i || s_ack_i || w_timeout) begin
          w_next_state = ST_IDLE;
          w_next_cnt   = 8'd0;
        end else begin
          w_next_cnt = r_cnt + 8'd1;
        end
      end
      ST_GRANT1: begin
        grant_o  = 2'b10;
        s_addr_o = m1_addr_i;
        s_data_o = m1_data_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_stb_o  = m1_stb_i;
        s_cyc_o  = m1_cyc_i;
        m1_ack_o = s_ack_i & w_req1;
        m1_err_o = m1_cyc_i & ~s_ack_i & w_timeout;
        if (!m1_cyc_i || s_ack_i || w_timeout) begin
          w_next_state = ST_IDLE;
          w_next_cnt   = 8'd0;
        end else begin
          w_next_cnt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Bench for rom_bus_arbiter: directed scenarios plus a randomized run
// checked cycle by cycle against a transaction-level arbitration model.
module tb_rom_bus_arbiter;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m_addr[2];
  logic [31:0] m_data[2];
  logic        m_we[2];
  logic [3:0]  m_sel[2];
  logic        m_stb[2];
  logic        m_cyc[2];
  logic [31:0] s_data_i;
  logic        s_ack_i;

  logic [31:0] m0_data_o, m1_data_o, s_addr_o, s_data_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_we_o, s_stb_o, s_cyc_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  grant_o, dbg_state_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  // model state: owner -1 = nobody granted
  int mdl_owner, mdl_wait, mdl_last;

  rom_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m_addr[0]), .m0_data_i(m_data[0]), .m0_we_i(m_we[0]),
    .m0_sel_i(m_sel[0]), .m0_stb_i(m_stb[0]), .m0_cyc_i(m_cyc[0]),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_addr_i(m_addr[1]), .m1_data_i(m_data[1]), .m1_we_i(m_we[1]),
    .m1_sel_i(m_sel[1]), .m1_stb_i(m_stb[1]), .m1_cyc_i(m_cyc[1]),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle_masters();
    for (int n = 0; n < 2; n++) begin
      m_addr[n] = '0; m_data[n] = '0; m_we[n] = 1'b0;
      m_sel[n] = '0; m_stb[n] = 1'b0; m_cyc[n] = 1'b0;
    end
    s_ack_i  = 1'b0;
    s_data_i = '0;
  endtask

  task automatic request(input int n, input logic [31:0] a, input logic [31:0] d,
                         input logic we, input logic [3:0] sel);
    m_addr[n] = a; m_data[n] = d; m_we[n] = we; m_sel[n] = sel;
    m_stb[n] = 1'b1; m_cyc[n] = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_masters();
    next_cycle();
    rst = 1'b0;
  endtask

  // reference model
  task automatic model_reset();
    mdl_owner = -1; mdl_wait = 0; mdl_last = 1;
  endtask

  function automatic logic [76:0] model_out();
    logic [76:0] v;
    int n;
    v = '0;
    if (mdl_owner >= 0) begin
      n = mdl_owner;
      v[76:75] = (n == 0) ? 2'b01 : 2'b10;
      v[74]    = m_cyc[n];
      v[73]    = m_stb[n];
      v[72]    = m_we[n];
      v[71:68] = m_sel[n];
      v[67:36] = m_addr[n];
      v[35:4]  = m_data[n];
      v[3 - 2*n] = s_ack_i & m_cyc[n] & m_stb[n];
      v[2 - 2*n] = m_cyc[n] & ~s_ack_i & (mdl_wait == TIMEOUT - 1);
    end
    return v;
  endfunction

  task automatic model_step();
    logic r0, r1;
    if (rst) begin
      model_reset();
    end else if (mdl_owner < 0) begin
      r0 = m_cyc[0] & m_stb[0];
      r1 = m_cyc[1] & m_stb[1];
      if (r0 && r1) mdl_owner = 1 - mdl_last;
      else if (r0)  mdl_owner = 0;
      else if (r1)  mdl_owner = 1;
      if (mdl_owner >= 0) begin
        mdl_last = mdl_owner;
        mdl_wait = 0;
      end
    end else if (!m_cyc[mdl_owner] || s_ack_i || mdl_wait == TIMEOUT - 1) begin
      mdl_owner = -1;
    end else begin
      mdl_wait++;
    end
  endtask

  function automatic logic [76:0] dut_out();
    return {grant_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o,
            m0_ack_o, m0_err_o, m1_ack_o, m1_err_o};
  endfunction

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    request(0, 32'h1111_0000, 32'h2222_0000, 1'b1, 4'hf);
    request(1, 32'h3333_0000, 32'h4444_0000, 1'b1, 4'h3);
    s_ack_i = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (dut_out() !== 77'd0) $display("FAIL reset_outputs got=%h exp=0", dut_out());
    else n_pass++;
    n_checks++;
    if (dbg_state_o !== 2'd0) $display("FAIL reset_state got=%0d exp=0", dbg_state_o);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    request(0, 32'h1000_0040, 32'h0, 1'b0, 4'hf);
    @(negedge clk);
    n_checks++;
    if (grant_o !== 2'b00) $display("FAIL sr_pre_grant got=%b exp=00", grant_o);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({grant_o, s_cyc_o, s_stb_o, s_addr_o, m0_ack_o} !== {2'b01, 1'b1, 1'b1, 32'h1000_0040, 1'b0})
      $display("FAIL sr_grant got=%b/%b%b/%h/%b exp=01/11/10000040/0", grant_o, s_cyc_o, s_stb_o, s_addr_o, m0_ack_o);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (m0_ack_o !== 1'b0) $display("FAIL sr_wait_ack got=%b exp=0", m0_ack_o);
    else n_pass++;
    next_cycle();
    s_ack_i = 1'b1; s_data_i = 32'hCAFE_0001;
    @(negedge clk);
    n_checks++;
    if ({m0_ack_o, m0_err_o, m1_ack_o, m0_data_o} !== {3'b100, 32'hCAFE_0001})
      $display("FAIL sr_ack got=%b%b%b/%h exp=100/cafe0001", m0_ack_o, m0_err_o, m1_ack_o, m0_data_o);
    else n_pass++;
    next_cycle();
    idle_masters();
    @(negedge clk);
    n_checks++;
    if ({grant_o, s_cyc_o, m0_ack_o} !== 4'b0000)
      $display("FAIL sr_release got=%b%b%b exp=0000", grant_o, s_cyc_o, m0_ack_o);
    else n_pass++;
  endtask

  task automatic test_tie_alternation();
    logic [1:0] exp_g;
    do_reset();
    request(0, 32'hA000_0000, 32'h0, 1'b0, 4'hf);
    request(1, 32'hB000_0000, 32'h0, 1'b0, 4'hf);
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      next_cycle();
      s_ack_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({grant_o, m0_ack_o, m1_ack_o} !== {exp_g, exp_g[0], exp_g[1]})
        $display("FAIL tie_grant_%0d got=%b/%b%b exp=%b", k, grant_o, m0_ack_o, m1_ack_o, exp_g);
      else n_pass++;
      next_cycle();
      s_ack_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({grant_o, s_cyc_o} !== 3'b000) $display("FAIL tie_idle_%0d got=%b%b exp=000", k, grant_o, s_cyc_o);
      else n_pass++;
    end
  endtask

  task automatic test_timeout(input logic ack_last);
    do_reset();
    request(0, 32'h0000_0100, 32'h0, 1'b0, 4'hf);
    for (int c = 1; c <= TIMEOUT; c++) begin
      next_cycle();
      s_ack_i = ack_last && (c == TIMEOUT);
      @(negedge clk);
      n_checks++;
      if ({grant_o, m0_ack_o, m0_err_o} !== {2'b01, s_ack_i, (c == TIMEOUT) && !ack_last})
        $display("FAIL timeout_cyc%0d_ack%0b got=%b/%b%b exp=01/%b%b", c, ack_last, grant_o,
                 m0_ack_o, m0_err_o, s_ack_i, (c == TIMEOUT) && !ack_last);
      else n_pass++;
    end
    next_cycle();
    s_ack_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({grant_o, m0_ack_o, m0_err_o} !== 4'b0000)
      $display("FAIL timeout_after_ack%0b got=%b%b%b exp=0000", ack_last, grant_o, m0_ack_o, m0_err_o);
    else n_pass++;
    idle_masters();
  endtask

  task automatic test_cyc_drop();
    do_reset();
    request(1, 32'h0000_2000, 32'h1234_5678, 1'b1, 4'h6);
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({grant_o, s_we_o, s_sel_o, s_data_o} !== {2'b10, 1'b1, 4'h6, 32'h1234_5678})
      $display("FAIL drop_grant got=%b/%b/%h/%h exp=10/1/6/12345678", grant_o, s_we_o, s_sel_o, s_data_o);
    else n_pass++;
    next_cycle();
    m_cyc[1] = 1'b0;
    s_ack_i  = 1'b1;
    request(0, 32'h0000_3000, 32'h0, 1'b0, 4'hf);
    @(negedge clk);
    n_checks++;
    if ({m1_ack_o, m1_err_o, m0_ack_o, m0_err_o} !== 4'b0000)
      $display("FAIL drop_no_ack got=%b%b%b%b exp=0000", m1_ack_o, m1_err_o, m0_ack_o, m0_err_o);
    else n_pass++;
    next_cycle();
    s_ack_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({grant_o, s_cyc_o} !== 3'b000) $display("FAIL drop_idle got=%b%b exp=000", grant_o, s_cyc_o);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({grant_o, s_addr_o} !== {2'b01, 32'h0000_3000})
      $display("FAIL drop_next_m0 got=%b/%h exp=01/00003000", grant_o, s_addr_o);
    else n_pass++;
    idle_masters();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    request(1, 32'h0000_4000, 32'h0, 1'b0, 4'hf);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    s_ack_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dut_out() !== 77'd0) $display("FAIL rst_midflight got=%h exp=0", dut_out());
    else n_pass++;
    idle_masters();
  endtask

  task automatic test_random();
    int ack_pct;
    int pcts[6] = '{0, 3, 25, 60, 90, 10};
    logic [76:0] exp_v, got_v;
    logic [31:0] exp_d;
    do_reset();
    model_reset();
    exp_q.delete();
    for (int blk = 0; blk < 6; blk++) begin
      ack_pct = pcts[blk];
      for (int c = 0; c < 400; c++) begin
        next_cycle();
        rst = ($urandom_range(0, 199) == 0);
        for (int n = 0; n < 2; n++) begin
          if ($urandom_range(0, 99) < 15) m_cyc[n] = ~m_cyc[n];
          m_stb[n]  = m_cyc[n] & ($urandom_range(0, 9) != 0);
          m_addr[n] = $urandom;
          m_data[n] = $urandom;
          m_we[n]   = 1'($urandom_range(0, 1));
          m_sel[n]  = 4'($urandom_range(0, 15));
        end
        s_ack_i  = ($urandom_range(0, 99) < ack_pct);
        s_data_i = $urandom;
        @(negedge clk);
        exp_v = model_out();
        got_v = dut_out();
        n_checks++;
        if (got_v !== exp_v) $display("FAIL rand_b%0d_c%0d got=%h exp=%h", blk, c, got_v, exp_v);
        else n_pass++;
        if (exp_v[3] || exp_v[1]) exp_q.push_back(s_data_i);
        if (m0_ack_o || m1_ack_o) begin
          exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : ~s_data_i;
          n_checks++;
          if ((m0_ack_o ? m0_data_o : m1_data_o) !== exp_d)
            $display("FAIL rand_ack_data got=%h exp=%h", m0_ack_o ? m0_data_o : m1_data_o, exp_d);
          else n_pass++;
        end
        model_step();
      end
    end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL rand_missing_acks got=%0d exp=0", exp_q.size());
    else n_pass++;
    rst = 1'b0;
    idle_masters();
  endtask

  initial begin
    idle_masters();
    test_reset();
    test_single_read();
    test_tie_alternation();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_cyc_drop();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
